// File: rtl/cpu_op_driver.sv
// cpu_op_driver: drives the CPU switch/operation/enable interface for one
// command at a time and returns the sampled CPU result on a response channel.
//
// Handshakes (both channels): a transfer happens on a rising clock edge where
// valid and ready are both high. Once raised, valid and its payload stay
// stable until that transfer. ready may change freely and carries no meaning
// while valid is low.
module cpu_op_driver #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int WAIT_CYCLES   = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [1:0]       cmd_op,
  output logic             SW0,
  output logic             SW1,
  output logic             SW2,
  output logic             SW3,
  output logic             SW4,
  output logic             SW5,
  output logic             SW6,
  output logic             SW7,
  output logic [1:0]       operation,
  output logic             enable,
  input  logic [3:0]       rezult,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_data,
  output logic [1:0]       rsp_op,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  // Phase counter must reach the largest of the three programmable lengths
  // (WAIT counts 0..WAIT_CYCLES inclusive).
  localparam int MAX_A   = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_CYC = (MAX_A > WAIT_CYCLES) ? MAX_A : WAIT_CYCLES;
  localparam int CW      = (MAX_CYC < 1) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] WAIT_LAST   = CW'(WAIT_CYCLES);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    sw_q;

  assign {SW7, SW6, SW5, SW4, SW3, SW2, SW1, SW0} = sw_q;

  // Ready only in IDLE and never while reset is held, so nothing is accepted
  // during reset.
  assign cmd_ready = reset_n && (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Transaction sequencer: all CPU-facing and response outputs are registered
  // here; reset returns enable high immediately and drops any transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      sw_q      <= '0;
      operation <= '0;
      enable    <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_op    <= '0;
      txn_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            sw_q      <= {cmd_b, cmd_a};
            operation <= cmd_op;
            cnt       <= '0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt    <= '0;
            enable <= 1'b0;
            state  <= S_STROBE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_STROBE: begin
          if (cnt == STROBE_LAST) begin
            cnt    <= '0;
            enable <= 1'b1;
            state  <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          // Settle for WAIT_CYCLES, then sample the CPU result on the next edge.
          if (cnt == WAIT_LAST) begin
            cnt       <= '0;
            rsp_data  <= rezult;
            rsp_op    <= operation;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            txn_count <= txn_count + CNT_W'(1);
            state     <= S_IDLE;
          end
        end
        default: begin
          cnt       <= '0;
          enable    <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
